// File: rtl/ghost_move_ctrl_if.sv
// Signal bundle between the ghost move controller and its environment:
// move request, distance-map read port and ghost position outputs.
interface ghost_move_ctrl_if;
    logic       move_tick;
    logic       map_ready;
    logic [7:0] data;
    logic [5:0] rdaddr_x;
    logic [4:0] rdaddr_y;
    logic [5:0] ghost_x;
    logic [4:0] ghost_y;
    logic [5:0] prev_x;
    logic [4:0] prev_y;
    logic       move_done;
    logic       busy;

    modport master (
        output move_tick, map_ready, data,
        input  rdaddr_x, rdaddr_y, ghost_x, ghost_y, prev_x, prev_y, move_done, busy
    );

    modport slave (
        input  move_tick, map_ready, data,
        output rdaddr_x, rdaddr_y, ghost_x, ghost_y, prev_x, prev_y, move_done, busy
    );
endinterface

// File: rtl/ghost_move_ctrl.sv
// Ghost step decision: reads the four neighbours of the ghost from the distance
// map, picks the cheapest legal one and updates current/previous positions.
//
// state    | meaning
// ---------|---------------------------------------------------------------
// S_IDLE   | waiting for a pending move request with the map valid
// S_READ   | presenting neighbour k for RD_LAT cycles, sampling its cost
// S_DECIDE | choosing the lowest-rank legal neighbour and moving the ghost
module ghost_move_ctrl #(
    parameter int START_X = 16,
    parameter int START_Y = 13,
    parameter int RD_LAT  = 2
) (
    input logic              CLOCK_50,
    input logic              reset,
    ghost_move_ctrl_if.slave bus
);
    localparam int            CW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] LAT_LOAD = CW'(RD_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DECIDE} state_t;

    state_t        state_q, state_d;
    logic          pending_q, pending_d;
    logic [1:0]    k_q, k_d;
    logic [CW-1:0] lat_q, lat_d;
    logic [7:0]    cost_q [4];
    logic [7:0]    cost_d [4];
    logic [5:0]    rdx_q, rdx_d;
    logic [4:0]    rdy_q, rdy_d;
    logic [5:0]    gx_q, gx_d, px_q, px_d;
    logic [4:0]    gy_q, gy_d, py_q, py_d;
    logic          done_q, done_d;

    logic [5:0]    nb_x [4];
    logic [4:0]    nb_y [4];
    logic          nb_ok [4];
    logic [5:0]    rd_x [4];
    logic [4:0]    rd_y [4];
    logic [1:0]    k_nxt;
    logic          found;
    logic [1:0]    best;
    logic [8:0]    best_rank;
    logic [8:0]    cand_rank;

    // Neighbour order doubles as tie-break priority: up, left, down, right.
    always_comb begin
        nb_x[0]  = gx_q;         nb_y[0] = gy_q - 5'd1; nb_ok[0] = (gy_q != 5'd0);
        nb_x[1]  = gx_q - 6'd1;  nb_y[1] = gy_q;        nb_ok[1] = (gx_q != 6'd0);
        nb_x[2]  = gx_q;         nb_y[2] = gy_q + 5'd1; nb_ok[2] = (gy_q < 5'd29);
        nb_x[3]  = gx_q + 6'd1;  nb_y[3] = gy_q;        nb_ok[3] = (gx_q < 6'd39);
        for (int j = 0; j < 4; j++) begin
            rd_x[j] = nb_ok[j] ? nb_x[j] : gx_q;
            rd_y[j] = nb_ok[j] ? nb_y[j] : gy_q;
        end
    end

    assign k_nxt = k_q + 2'd1;

    // 253 (prior ghost cell) ranks above every ordinary cost; 254/255 excluded.
    always_comb begin
        found     = 1'b0;
        best      = 2'd0;
        best_rank = '1;
        cand_rank = '0;
        for (int j = 0; j < 4; j++) begin
            cand_rank = {cost_q[j] == 8'd253, cost_q[j]};
            if (cost_q[j] < 8'd254 && (!found || cand_rank < best_rank)) begin
                found     = 1'b1;
                best      = 2'(j);
                best_rank = cand_rank;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        k_d       = k_q;
        lat_d     = lat_q;
        cost_d    = cost_q;
        rdx_d     = rdx_q;
        rdy_d     = rdy_q;
        gx_d      = gx_q;
        gy_d      = gy_q;
        px_d      = px_q;
        py_d      = py_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q && bus.map_ready) begin
                    pending_d = 1'b0;
                    k_d       = 2'd0;
                    lat_d     = LAT_LOAD;
                    rdx_d     = rd_x[0];
                    rdy_d     = rd_y[0];
                    state_d   = S_READ;
                end else if (bus.move_tick) begin
                    pending_d = 1'b1;
                end
            end
            S_READ: begin
                if (lat_q == '0) begin
                    cost_d[k_q] = nb_ok[k_q] ? bus.data : 8'hFF;
                    if (k_q != 2'd3) begin
                        k_d   = k_nxt;
                        lat_d = LAT_LOAD;
                        rdx_d = rd_x[k_nxt];
                        rdy_d = rd_y[k_nxt];
                    end else begin
                        state_d = S_DECIDE;
                    end
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            S_DECIDE: begin
                if (found) begin
                    px_d = gx_q;
                    py_d = gy_q;
                    gx_d = nb_x[best];
                    gy_d = nb_y[best];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            k_q       <= 2'd0;
            lat_q     <= '0;
            for (int j = 0; j < 4; j++) cost_q[j] <= 8'd0;
            rdx_q     <= 6'd0;
            rdy_q     <= 5'd0;
            gx_q      <= 6'(START_X);
            gy_q      <= 5'(START_Y);
            px_q      <= 6'(START_X);
            py_q      <= 5'(START_Y);
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            k_q       <= k_d;
            lat_q     <= lat_d;
            cost_q    <= cost_d;
            rdx_q     <= rdx_d;
            rdy_q     <= rdy_d;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            px_q      <= px_d;
            py_q      <= py_d;
            done_q    <= done_d;
        end
    end

    assign bus.rdaddr_x  = rdx_q;
    assign bus.rdaddr_y  = rdy_q;
    assign bus.ghost_x   = gx_q;
    assign bus.ghost_y   = gy_q;
    assign bus.prev_x    = px_q;
    assign bus.prev_y    = py_q;
    assign bus.move_done = done_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_ghost_move_ctrl.sv
// Bench for ghost_move_ctrl: a map array feeds a one-cycle-delayed read port,
// and a neighbour-ranking model predicts every move.
module tb_ghost_move_ctrl;
    localparam int RD_LAT = 2;
    localparam int LAT    = 4 * RD_LAT + 2;  // tick-sample edge to move_done

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ghost_move_ctrl_if bus();

    ghost_move_ctrl #(.START_X(16), .START_Y(13), .RD_LAT(RD_LAT)) dut (
        .CLOCK_50(clk),
        .reset   (rst_n),
        .bus     (bus)
    );

    logic [7:0] map [40][30];
    int cyc = 0;
    int done_cnt = 0;
    int bad_addr = 0;
    int n_chk = 0;
    int n_fail = 0;
    int mgx, mgy, mpx, mpy, exp_done;

    typedef struct {
        int u, l, d, r, dx, dy;
    } vec_t;
    vec_t vt [10];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (int'(bus.rdaddr_x) < 40 && int'(bus.rdaddr_y) < 30)
            bus.data <= map[int'(bus.rdaddr_x)][int'(bus.rdaddr_y)];
        else
            bus.data <= 8'h00;
    end

    always @(negedge clk) begin
        if (bus.move_done) done_cnt <= done_cnt + 1;
        if (int'(bus.rdaddr_x) > 39 || int'(bus.rdaddr_y) > 29) bad_addr <= bad_addr + 1;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", nm, act, exp);
        end
    endtask

    function automatic void model_reset();
        mgx = 16; mgy = 13; mpx = 16; mpy = 13;
    endfunction

    // Cheapest legal neighbour; a cell just vacated (253) counts as dearer than any open cell.
    function automatic void model_step();
        int dxs [4] = '{0, -1, 0, 1};
        int dys [4] = '{-1, 0, 1, 0};
        int best = -1;
        int bkey = 1000;
        int nx, ny, v, key;
        for (int i = 0; i < 4; i++) begin
            nx = mgx + dxs[i];
            ny = mgy + dys[i];
            if (nx >= 0 && nx < 40 && ny >= 0 && ny < 30) begin
                v = int'(map[nx][ny]);
                if (v < 254) begin
                    key = (v == 253) ? 300 : v;
                    if (key < bkey) begin
                        bkey = key;
                        best = i;
                    end
                end
            end
        end
        if (best >= 0) begin
            mpx = mgx; mpy = mgy;
            mgx = mgx + dxs[best];
            mgy = mgy + dys[best];
        end
    endfunction

    task automatic set_cell(input int x, input int y, input int v);
        if (x >= 0 && x < 40 && y >= 0 && y < 30) map[x][y] = 8'(v);
    endtask

    task automatic set_nb(input int u, input int l, input int d, input int r);
        set_cell(mgx, mgy - 1, u);
        set_cell(mgx - 1, mgy, l);
        set_cell(mgx, mgy + 1, d);
        set_cell(mgx + 1, mgy, r);
    endtask

    task automatic check_pos(input string nm);
        check({nm, " ghost_x"}, int'(bus.ghost_x), mgx);
        check({nm, " ghost_y"}, int'(bus.ghost_y), mgy);
        check({nm, " prev_x"}, int'(bus.prev_x), mpx);
        check({nm, " prev_y"}, int'(bus.prev_y), mpy);
    endtask

    task automatic run_move(input string nm);
        int t0;
        bit seen;
        seen = 1'b0;
        model_step();
        exp_done++;
        @(negedge clk) bus.move_tick = 1'b1;
        @(negedge clk) bus.move_tick = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.move_done) begin
                seen = 1'b1;
                break;
            end
        end
        check({nm, " done seen"}, int'(seen), 1);
        if (seen) begin
            check({nm, " latency"}, cyc - t0, LAT);
            check({nm, " busy at done"}, int'(bus.busy), 0);
            check_pos(nm);
            @(negedge clk);
            check({nm, " done width"}, int'(bus.move_done), 0);
        end
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        check_pos({nm, " rst"});
        check({nm, " rst rdaddr_x"}, int'(bus.rdaddr_x), 0);
        check({nm, " rst rdaddr_y"}, int'(bus.rdaddr_y), 0);
        check({nm, " rst busy"}, int'(bus.busy), 0);
        check({nm, " rst done"}, int'(bus.move_done), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int d0, ox, oy, r;
        bit seen;
        bus.move_tick = 1'b0;
        bus.map_ready = 1'b1;
        for (int x = 0; x < 40; x++)
            for (int y = 0; y < 30; y++) map[x][y] = 8'd100;
        exp_done = 0;
        model_reset();

        vt[0] = '{12, 12, 10, 10, 0, 1};
        vt[1] = '{253, 255, 255, 40, 1, 0};
        vt[2] = '{253, 255, 255, 255, 0, -1};
        vt[3] = '{255, 254, 255, 255, 0, 0};
        vt[4] = '{5, 5, 5, 5, 0, -1};
        vt[5] = '{252, 253, 253, 253, 0, -1};
        vt[6] = '{253, 253, 254, 255, 0, -1};
        vt[7] = '{100, 7, 7, 200, -1, 0};
        vt[8] = '{0, 1, 2, 3, 0, -1};
        vt[9] = '{253, 252, 255, 255, -1, 0};

        // reset and idle
        do_reset("init");
        repeat (20) @(negedge clk);
        check_pos("idle");
        check("idle busy", int'(bus.busy), 0);
        check("idle done count", done_cnt, 0);

        // table of relative neighbour costs
        for (int i = 0; i < 10; i++) begin
            ox = mgx; oy = mgy;
            set_nb(vt[i].u, vt[i].l, vt[i].d, vt[i].r);
            run_move($sformatf("vec%0d", i));
            check($sformatf("vec%0d table x", i), int'(bus.ghost_x), ox + vt[i].dx);
            check($sformatf("vec%0d table y", i), int'(bus.ghost_y), oy + vt[i].dy);
        end

        // reversal avoidance from the start cell, twice
        do_reset("rev1");
        set_nb(253, 255, 255, 40);
        run_move("rev right");
        check("rev right x", int'(bus.ghost_x), 17);
        do_reset("rev2");
        set_nb(253, 255, 255, 255);
        run_move("rev up");
        check("rev up y", int'(bus.ghost_y), 12);

        // handshake: wait on map_ready, drop extra tick, ignore ready loss mid-read
        set_nb(50, 60, 70, 30);
        model_step();
        exp_done++;
        d0 = done_cnt;
        bus.map_ready = 1'b0;
        @(negedge clk) bus.move_tick = 1'b1;
        @(negedge clk) bus.move_tick = 1'b0;
        repeat (5) @(negedge clk);
        check("hs idle without ready", int'(bus.busy), 0);
        bus.map_ready = 1'b1;
        @(negedge clk);
        check("hs start on ready", int'(bus.busy), 1);
        bus.move_tick = 1'b1;
        @(negedge clk) bus.move_tick = 1'b0;
        bus.map_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.move_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("hs done seen", int'(seen), 1);
        check_pos("hs");
        bus.map_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("hs single done", done_cnt - d0, 1);
        check("hs idle after", int'(bus.busy), 0);

        // asynchronous reset in the middle of the read phase
        set_nb(9, 8, 7, 6);
        d0 = done_cnt;
        @(negedge clk) bus.move_tick = 1'b1;
        @(negedge clk) bus.move_tick = 1'b0;
        @(posedge clk);
        #1 check("mid busy after start", int'(bus.busy), 1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_pos("mid rst");
        check("mid rst busy", int'(bus.busy), 0);
        check("mid rst rdaddr_x", int'(bus.rdaddr_x), 0);
        check("mid rst rdaddr_y", int'(bus.rdaddr_y), 0);
        check("mid rst done", int'(bus.move_done), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("mid no done", done_cnt - d0, 0);
        check_pos("mid after");

        // steer to the corner, then a fully blocked move there
        for (int i = 0; i < 60 && (mgx > 0 || mgy > 0); i++) begin
            if (mgx > 0) set_nb(200, 1, 200, 200);
            else         set_nb(1, 200, 200, 200);
            run_move("steer");
        end
        set_cell(0, 0, 0);
        set_cell(1, 0, 254);
        set_cell(0, 1, 255);
        run_move("corner");
        check("corner x", int'(bus.ghost_x), 0);
        check("corner y", int'(bus.ghost_y), 0);

        // random neighbourhoods
        for (int n = 0; n < 60; n++) begin
            for (int j = 0; j < 5; j++) begin
                r = $urandom_range(0, 9);
                r = (r < 3) ? 253 + r : int'($urandom_range(0, 252));
                case (j)
                    0: set_cell(mgx, mgy - 1, r);
                    1: set_cell(mgx - 1, mgy, r);
                    2: set_cell(mgx, mgy + 1, r);
                    3: set_cell(mgx + 1, mgy, r);
                    default: set_cell(mgx, mgy, r);
                endcase
            end
            run_move("rand");
        end

        repeat (5) @(negedge clk);
        check("rdaddr in grid", bad_addr, 0);
        check("total done pulses", done_cnt, exp_done);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout, required finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ghost_move_ctrl.md
# ghost_move_ctrl

Decides one ghost's next grid step from the ghost distance map. The ghost distance map controller is the producer: it exposes one 8-bit cell through `rdaddr_x`/`rdaddr_y` → `data` and raises `ready` once the map is valid. On each move request, this block reads the four orthogonal neighbours of the ghost, picks the cheapest legal one and updates the ghost's current and previous positions. Those positions feed back into the map controller as the `curr_ghost*`/`prev_ghost*` inputs.

## Interface
Parameters:
- `START_X`, default 16: ghost x after reset (0..39)
- `START_Y`, default 13: ghost y after reset (0..29)
- `RD_LAT`, default 2: cycles each map read is held before `data` is sampled (≥1)

Ports:
- `CLOCK_50`  in  1  sole clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low; all registers forced to reset values while low
- `move_tick`  in  1  one-cycle move request
- `map_ready`  in  1  distance map valid (driven by map controller `ready`)
- `data`  in  8  map cell at (`rdaddr_x`, `rdaddr_y`)
- `rdaddr_x`  out  6  map read column, registered
- `rdaddr_y`  out  5  map read row, registered
- `ghost_x`  out  6  current ghost column, registered
- `ghost_y`  out  5  current ghost row, registered
- `prev_x`  out  6  ghost column before last move, registered
- `prev_y`  out  5  ghost row before last move, registered
- `move_done`  out  1  one-cycle pulse when `ghost_x/y` updates
- `busy`  out  1  high in any state other than IDLE

## Operation
- Reset values:
  - `ghost_x = prev_x = START_X`, `ghost_y = prev_y = START_Y`
  - `rdaddr_x = 0`, `rdaddr_y = 0`
  - `move_done = 0`, `busy = 0`, `pending = 0`, state IDLE
- `pending` flag:
  - Set by `move_tick` while in IDLE.
  - Ticks arriving while busy are dropped, not queued.
- States: IDLE → READ → DECIDE → IDLE.
- IDLE:
  - When `pending && map_ready`: clear `pending`, set neighbour index k=0, load `rdaddr` with neighbour 0, go to READ.
- READ:
  - Each neighbour holds `rdaddr` for exactly `RD_LAT` cycles.
  - On the last of those cycles, sample `data` into `cost[k]`.
  - If k<3: advance k and load the next neighbour address on the same edge. If k==3: go to DECIDE.
- Neighbour order is also the tie-break priority: 0 up (y−1), 1 left (x−1), 2 down (y+1), 3 right (x+1).
- Off-grid neighbours (x<0, x>39, y<0, y>29):
  - No wrap-around.
  - Still consume `RD_LAT` cycles, with `rdaddr` held at the ghost's own cell.
  - `cost` is forced to 255 regardless of `data`.
- Cost classes:
  - 255 (wall) and 254 (ghost) are blocked.
  - 253 (prior ghost cell) is legal but ranks above every value 0..252.
  - 0..252 rank by value.
  - Implement as 9-bit rank = {cost==253, cost}; blocked candidates are excluded.
- DECIDE, one cycle:
  - Choose the minimum rank; ties go to the lowest index.
  - On exit: `prev_x/y <= ghost_x/y`, `ghost_x/y <=` chosen cell, `move_done <= 1`.
- All four blocked:
  - `ghost_x/y` and `prev_x/y` unchanged.
  - `move_done` still pulses.
- `map_ready` dropping during READ is ignored; the move completes with the sampled values.

## Timing
- Start edge = the IDLE edge where `pending && map_ready` is true.
- `busy` is high from the start edge until the DECIDE exit edge.
- `move_done` is high for the single cycle after the DECIDE exit edge.
  - Asserted 4·`RD_LAT`+1 cycles after the start edge (9 cycles at default).
- `ghost_x/y` and `prev_x/y` change only on the DECIDE exit edge.
- Earliest next start is the cycle after `move_done` rises, if a new tick is pending.
- `move_tick` in the same cycle as `move_done` is accepted, because the block is already in IDLE.
- Reset low mid-move: immediate return to reset values; the partial move is discarded.

## Test plan
- Reset and idle: hold reset low, then release with no tick → `ghost=(16,13)`, `prev=(16,13)`, `move_done=0`, `busy=0` indefinitely.
- Tie-break: ghost (16,13); model map costs up=12, left=12, down=10, right=10; tick with `map_ready=1` → after 9 cycles `ghost=(16,14)`, `prev=(16,13)`, one-cycle `move_done`.
- Reversal avoidance: up=253, left=255, down=255, right=40 → moves right to (17,13). Then set right=255 and rerun from the same position → moves up.
- Fully blocked and edge of grid: ghost (0,0) with right=254 and down=255 → position unchanged, `move_done` pulses. `rdaddr` never presents x=63 or y=31.
- Handshake: tick with `map_ready=0` → stays IDLE. Raise `map_ready` 5 cycles later → move starts that cycle. A second tick during `busy` → exactly one `move_done`.
- Async reset mid-READ: drive reset low 3 cycles after the start edge (no clock edge needed) → outputs return to reset values at once, and no `move_done` occurs.
